ahb_decoder9: RTL and testbench

//  AHB-Lite address-phase decoder and default slave for the 8-slave interconnect.
//  - Decodes HADDR into a one-hot HSEL to slaves 0..7, or to the default slave (bit 8).
//  - Registers the data-phase select that drives sel0..sel8 of the 9:1 response mux (read data, hreadyout, hresp).
//  - Contains the default slave, which returns a two-cycle ERROR response for active transfers to unmapped space.

---
 rtl/ahb_decoder9.sv | 109 ++++++++++
 tb/tb_ahb_decoder9.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder9.sv
// AHB-Lite address decoder, data-phase response-mux select and default (error) slave.
// Latency: hsel combinational, resp_sel/default-slave outputs one cycle later; resp_sel holds while hready is low.
module ahb_decoder9 #(
    parameter int AW      = 32,
    parameter int REG_MSB = 31,
    parameter int REG_LSB = 28,
    parameter int NMAP    = 8
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hready,
    output logic [8:0]    hsel,
    output logic [8:0]    resp_sel,
    output logic          def_hreadyout,
    output logic          def_hresp
);

    localparam int RW = REG_MSB - REG_LSB + 1;
    localparam logic [RW-1:0] NMAP_R = RW'(NMAP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    logic [RW-1:0] region;
    logic          acc;
    logic          unused_in;
    state_t        state_q;
    state_t        state_d;
    logic          hreadyout_d;
    logic          hresp_d;

    assign region    = haddr[REG_MSB:REG_LSB];
    assign unused_in = ^{haddr, htrans[0]};

    // region < NMAP <= 8 guarantees the low three bits carry the whole slave index
    always_comb begin
        hsel = '0;
        if (region < NMAP_R) begin
            hsel[{1'b0, region[2:0]}] = 1'b1;
        end else begin
            hsel[8] = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            resp_sel <= 9'h100;
        end else if (hready) begin
            resp_sel <= hsel;
        end
    end

    assign acc = hsel[8] & hready & htrans[1];

    always_comb begin
        state_d     = state_q;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    state_d = S_ERR1;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            S_ERR2: begin
                state_d = acc ? S_ERR1 : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // outputs are decoded from the next state so they leave a flop
        case (state_d)
            S_ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = 1'b1;
            end
            S_ERR2: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b1;
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q       <= S_IDLE;
            def_hreadyout <= 1'b1;
            def_hresp     <= 1'b0;
        end else begin
            state_q       <= state_d;
            def_hreadyout <= hreadyout_d;
            def_hresp     <= hresp_d;
        end
    end

endmodule

// File: tb/tb_ahb_decoder9.sv
// Bench for ahb_decoder9: directed AHB sequences plus random traffic against a queue-based response model.
module tb_ahb_decoder9;

    logic        hclk    = 1'b0;
    logic        hresetn = 1'b0;
    logic [31:0] haddr   = '0;
    logic [1:0]  htrans  = 2'b00;
    logic        slave_rdy = 1'b1;
    logic        hready;
    logic [8:0]  hsel;
    logic [8:0]  resp_sel;
    logic        def_hreadyout;
    logic        def_hresp;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    ahb_decoder9 dut (
        .hclk          (hclk),
        .hresetn       (hresetn),
        .haddr         (haddr),
        .htrans        (htrans),
        .hready        (hready),
        .hsel          (hsel),
        .resp_sel      (resp_sel),
        .def_hreadyout (def_hreadyout),
        .def_hresp     (def_hresp)
    );

    always #5 hclk = ~hclk;

    // global HREADY as the response mux would produce it
    assign hready = resp_sel[8] ? def_hreadyout : slave_rdy;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_decode(input logic [31:0] a);
        int r;
        r = int'(a >> 28);
        if (r < 8) return 9'(1 << r);
        return 9'h100;
    endfunction

    typedef struct packed {
        logic [8:0] sel;
        logic       hro;
        logic       hresp;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] pend[$];
    logic [8:0] m_sel = 9'h100;
    logic [8:0] m_hs;
    logic       m_acc;
    logic [1:0] m_rsp;
    exp_t       mon_e;

    // reference model: an accepted unmapped active transfer queues a two-beat ERROR response
    initial begin
        forever begin
            @(negedge hclk);
            chk("hsel", 32'(hsel), 32'(ref_decode(haddr)));
            if (!hresetn) begin
                m_sel = 9'h100;
                pend.delete();
                sb.push_back(exp_t'{9'h100, 1'b1, 1'b0});
            end else begin
                m_hs  = ref_decode(haddr);
                m_acc = m_hs[8] && hready && htrans[1];
                if (pend.size() != 0) begin
                    m_rsp = pend.pop_front();
                end else if (m_acc) begin
                    pend.push_back(2'b11);
                    m_rsp = 2'b01;
                end else begin
                    m_rsp = 2'b10;
                end
                if (hready) m_sel = m_hs;
                sb.push_back(exp_t'{m_sel, m_rsp[1], m_rsp[0]});
            end
        end
    end

    initial begin
        forever begin
            @(posedge hclk);
            #1;
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_resp_sel", 32'(resp_sel), 32'(mon_e.sel));
                chk("sb_def_hreadyout", 32'(def_hreadyout), 32'(mon_e.hro));
                chk("sb_def_hresp", 32'(def_hresp), 32'(mon_e.hresp));
            end
        end
    end

    task automatic step();
        @(posedge hclk);
        #2;
    endtask

    task automatic set(input logic [31:0] a, input logic [1:0] t);
        haddr  = a;
        htrans = t;
    endtask

    task automatic chk_def(input string name, input logic hro, input logic hrsp);
        chk(name, 32'({def_hreadyout, def_hresp}), 32'({hro, hrsp}));
    endtask

    initial begin
        // reset: hsel follows haddr while registers stay cleared
        repeat (4) begin
            step();
            haddr = $urandom;
            #1 chk("hsel_in_reset", 32'(hsel), 32'(ref_decode(haddr)));
        end
        chk("reset_resp_sel", 32'(resp_sel), 32'h100);
        chk_def("reset_def", 1'b1, 1'b0);
        set(32'h0, T_IDLE);
        hresetn = 1'b1;
        step();

        // mapped transfer
        set(32'h3000_0000, T_NSEQ);
        #1 chk("hsel_slave3", 32'(hsel), 32'h008);
        step();
        chk("resp_sel_slave3", 32'(resp_sel), 32'h008);

        // single error response
        set(32'hA000_0000, T_NSEQ);
        #1 chk("hsel_unmapped", 32'(hsel), 32'h100);
        step();
        chk_def("err_beat1", 1'b0, 1'b1);
        set(32'h0, T_IDLE);
        step();
        chk_def("err_beat2", 1'b1, 1'b1);
        step();
        chk_def("err_done", 1'b1, 1'b0);

        // back-to-back errors, second address held through ERR1
        set(32'hF000_0000, T_NSEQ);
        step();
        chk_def("b2b_err1a", 1'b0, 1'b1);
        set(32'hF000_0004, T_SEQ);
        step();
        chk_def("b2b_err2a", 1'b1, 1'b1);
        step();
        chk_def("b2b_err1b", 1'b0, 1'b1);
        set(32'h0, T_IDLE);
        step();
        chk_def("b2b_err2b", 1'b1, 1'b1);
        step();
        chk_def("b2b_idle", 1'b1, 1'b0);

        // IDLE/BUSY to unmapped space: zero-wait OKAY
        set(32'h9000_0000, T_IDLE);
        step();
        chk_def("idle_unmapped", 1'b1, 1'b0);
        set(32'h9000_0000, T_BUSY);
        step();
        chk_def("busy_unmapped", 1'b1, 1'b0);
        step();
        chk_def("busy_unmapped2", 1'b1, 1'b0);

        // wait states on a mapped slave hold resp_sel
        set(32'h3000_0000, T_NSEQ);
        step();
        slave_rdy = 1'b0;
        repeat (3) begin
            set($urandom, T_NSEQ);
            step();
            chk("resp_sel_hold", 32'(resp_sel), 32'h008);
        end
        slave_rdy = 1'b1;

        // reset during ERR1
        set(32'hA000_0000, T_NSEQ);
        step();
        chk_def("err1_pre_reset", 1'b0, 1'b1);
        hresetn = 1'b0;
        #1;
        chk_def("async_reset_def", 1'b1, 1'b0);
        chk("async_reset_resp_sel", 32'(resp_sel), 32'h100);
        step();
        hresetn = 1'b1;
        set(32'h0, T_IDLE);
        step();
        chk_def("post_reset_def", 1'b1, 1'b0);

        // random traffic
        repeat (3000) begin
            set($urandom, 2'($urandom_range(0, 3)));
            slave_rdy = ($urandom_range(0, 3) != 0);
            hresetn   = ($urandom_range(0, 199) != 0);
            step();
        end
        hresetn = 1'b1;
        set(32'h0, T_IDLE);
        slave_rdy = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
